multicycle_control: RTL and testbench

//  Multi-cycle MIPS control FSM; successor to the single-cycle opcode decoder. Sequences fetch/decode/execute/

---
 rtl/mips_pkg.sv | 78 +++++++
 rtl/multicycle_control_if.sv | 52 +++++
 rtl/multicycle_control_outdec.sv | 80 ++++++++
 rtl/multicycle_control.sv | 119 +++++++++++
 tb/tb_multicycle_control.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS controller: opcodes, ALU classes,
// FSM states, mux-select encodings and the packed control word.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [2:0] ALU_LUI   = 3'b011;
    localparam logic [2:0] ALU_ADD   = 3'b100;
    localparam logic [2:0] ALU_SUB   = 3'b101;
    localparam logic [2:0] ALU_OR    = 3'b110;
    localparam logic [2:0] ALU_RTYPE = 3'b111;

    localparam logic       SRCA_PC      = 1'b0;
    localparam logic       SRCA_RS      = 1'b1;
    localparam logic [1:0] SRCB_RT      = 2'd0;
    localparam logic [1:0] SRCB_FOUR    = 2'd1;
    localparam logic [1:0] SRCB_IMM     = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH  = 2'd3;
    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;
    localparam logic [1:0] RDST_RT      = 2'd0;
    localparam logic [1:0] RDST_RD      = 2'd1;
    localparam logic [1:0] RDST_RA      = 2'd2;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_R_EXEC    = 4'd2,
        S_R_WB      = 4'd3,
        S_ADDI_EXEC = 4'd4,
        S_ORI_EXEC  = 4'd5,
        S_LUI_EXEC  = 4'd6,
        S_I_WB      = 4'd7,
        S_MEM_ADDR  = 4'd8,
        S_MEM_RD    = 4'd9,
        S_MEM_WB    = 4'd10,
        S_MEM_WR    = 4'd11,
        S_BRANCH    = 4'd12,
        S_JUMP      = 4'd13
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       branch_eq;
        logic       branch_ne;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic [1:0] reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [2:0] alu_op;
        logic       illegal;
    } ctrl_t;

    function automatic logic is_legal(input logic [5:0] op);
        case (op)
            OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE,
            OP_ADDI, OP_ORI, OP_LUI, OP_LW, OP_SW: is_legal = 1'b1;
            default:                               is_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath bundle: opcode/mem_ready in, control word out.
// Perf counter signals exist only when MC_CTRL_PERF_EN is defined.
interface multicycle_control_if #(
    parameter int ALU_OP_W = 3,
    parameter int STATE_W  = 4
`ifdef MC_CTRL_PERF_EN
    , parameter int CNT_W  = 32
`endif
);
    logic [5:0]          opcode_i;
    logic                mem_ready_i;
    logic                pc_write_o;
    logic                branch_eq_o;
    logic                branch_ne_o;
    logic                i_or_d_o;
    logic                mem_read_o;
    logic                mem_write_o;
    logic                ir_write_o;
    logic                mem_to_reg_o;
    logic [1:0]          reg_dst_o;
    logic                reg_write_o;
    logic                alu_src_a_o;
    logic [1:0]          alu_src_b_o;
    logic [1:0]          pc_source_o;
    logic [ALU_OP_W-1:0] alu_op_o;
    logic                illegal_o;
    logic [STATE_W-1:0]  state_o;
`ifdef MC_CTRL_PERF_EN
    logic [CNT_W-1:0]    instr_cnt_o;
    logic [CNT_W-1:0]    stall_cnt_o;
`endif

    modport master (
        input  opcode_i, mem_ready_i,
`ifdef MC_CTRL_PERF_EN
        output instr_cnt_o, stall_cnt_o,
`endif
        output pc_write_o, branch_eq_o, branch_ne_o, i_or_d_o, mem_read_o,
               mem_write_o, ir_write_o, mem_to_reg_o, reg_dst_o, reg_write_o,
               alu_src_a_o, alu_src_b_o, pc_source_o, alu_op_o, illegal_o, state_o
    );

    modport slave (
        output opcode_i, mem_ready_i,
`ifdef MC_CTRL_PERF_EN
        input  instr_cnt_o, stall_cnt_o,
`endif
        input  pc_write_o, branch_eq_o, branch_ne_o, i_or_d_o, mem_read_o,
               mem_write_o, ir_write_o, mem_to_reg_o, reg_dst_o, reg_write_o,
               alu_src_a_o, alu_src_b_o, pc_source_o, alu_op_o, illegal_o, state_o
    );
endinterface

// File: rtl/multicycle_control_outdec.sv
// State -> control word decoder (Moore, except FETCH's pc/ir write gated by
// mem_ready and the DECODE-cycle illegal flag taken from the live opcode).
module multicycle_control_outdec
    import mips_pkg::*;
(
    input  state_t     i_state,
    input  logic [5:0] i_opcode,
    input  logic [5:0] i_dec_opcode,
    input  logic       i_mem_ready,
    output ctrl_t      o_ctrl
);
    always_comb begin
        o_ctrl = '0;
        case (i_state)
            S_FETCH: begin
                o_ctrl.mem_read  = 1'b1;
                o_ctrl.alu_src_a = SRCA_PC;
                o_ctrl.alu_src_b = SRCB_FOUR;
                o_ctrl.alu_op    = ALU_ADD;
                o_ctrl.pc_source = PCSRC_ALU;
                o_ctrl.ir_write  = i_mem_ready;
                o_ctrl.pc_write  = i_mem_ready;
            end
            S_DECODE: begin
                o_ctrl.alu_src_a = SRCA_PC;
                o_ctrl.alu_src_b = SRCB_IMM_SH;
                o_ctrl.alu_op    = ALU_ADD;
                o_ctrl.illegal   = ~is_legal(i_dec_opcode);
            end
            S_R_EXEC: begin
                o_ctrl.alu_src_a = SRCA_RS;
                o_ctrl.alu_src_b = SRCB_RT;
                o_ctrl.alu_op    = ALU_RTYPE;
            end
            S_R_WB: begin
                o_ctrl.reg_dst   = RDST_RD;
                o_ctrl.reg_write = 1'b1;
            end
            S_ADDI_EXEC, S_ORI_EXEC, S_LUI_EXEC, S_MEM_ADDR: begin
                o_ctrl.alu_src_a = SRCA_RS;
                o_ctrl.alu_src_b = SRCB_IMM;
                o_ctrl.alu_op    = (i_state == S_ORI_EXEC) ? ALU_OR :
                                   (i_state == S_LUI_EXEC) ? ALU_LUI : ALU_ADD;
            end
            S_I_WB: begin
                o_ctrl.reg_dst   = RDST_RT;
                o_ctrl.reg_write = 1'b1;
            end
            S_MEM_RD: begin
                o_ctrl.mem_read = 1'b1;
                o_ctrl.i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                o_ctrl.mem_to_reg = 1'b1;
                o_ctrl.reg_dst    = RDST_RT;
                o_ctrl.reg_write  = 1'b1;
            end
            S_MEM_WR: begin
                o_ctrl.mem_write = 1'b1;
                o_ctrl.i_or_d    = 1'b1;
            end
            S_BRANCH: begin
                o_ctrl.alu_src_a = SRCA_RS;
                o_ctrl.alu_src_b = SRCB_RT;
                o_ctrl.alu_op    = ALU_SUB;
                o_ctrl.pc_source = PCSRC_ALUOUT;
                o_ctrl.branch_eq = (i_opcode == OP_BEQ);
                o_ctrl.branch_ne = (i_opcode == OP_BNE);
            end
            S_JUMP: begin
                // JAL links PC (already PC+4) into $ra; mem_to_reg stays 0.
                o_ctrl.pc_source = PCSRC_JUMP;
                o_ctrl.pc_write  = 1'b1;
                o_ctrl.reg_write = (i_opcode == OP_JAL);
                o_ctrl.reg_dst   = (i_opcode == OP_JAL) ? RDST_RA : RDST_RT;
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM with shared ALU/memory sequencing.
// Optional performance counters enabled by defining MC_CTRL_PERF_EN.
module multicycle_control
    import mips_pkg::*;
#(
    parameter int ALU_OP_W = 3,
    parameter int STATE_W  = 4
`ifdef MC_CTRL_PERF_EN
    , parameter int CNT_W  = 32
`endif
) (
    input  logic                 clk,
    input  logic                 reset,
    multicycle_control_if.master bus
);
    state_t     r_state;
    state_t     w_next_state;
    logic [5:0] r_opcode;
    ctrl_t      w_ctrl;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_FETCH;
        else        r_state <= w_next_state;
    end

    // Opcode is captured once so later IR-field changes cannot steer the instruction.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                    r_opcode <= '0;
        else if (r_state == S_DECODE)  r_opcode <= bus.opcode_i;
    end

    always_comb begin
        w_next_state = S_FETCH;
        case (r_state)
            S_FETCH:  w_next_state = bus.mem_ready_i ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (bus.opcode_i)
                    OP_RTYPE:       w_next_state = S_R_EXEC;
                    OP_LW, OP_SW:   w_next_state = S_MEM_ADDR;
                    OP_ADDI:        w_next_state = S_ADDI_EXEC;
                    OP_ORI:         w_next_state = S_ORI_EXEC;
                    OP_LUI:         w_next_state = S_LUI_EXEC;
                    OP_BEQ, OP_BNE: w_next_state = S_BRANCH;
                    OP_J, OP_JAL:   w_next_state = S_JUMP;
                    default:        w_next_state = S_FETCH;
                endcase
            end
            S_R_EXEC:    w_next_state = S_R_WB;
            S_ADDI_EXEC,
            S_ORI_EXEC,
            S_LUI_EXEC:  w_next_state = S_I_WB;
            S_MEM_ADDR:  w_next_state = (r_opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:    w_next_state = bus.mem_ready_i ? S_MEM_WB : S_MEM_RD;
            S_MEM_WR:    w_next_state = bus.mem_ready_i ? S_FETCH : S_MEM_WR;
            default:     w_next_state = S_FETCH;
        endcase
    end

    multicycle_control_outdec u_outdec (
        .i_state      (r_state),
        .i_opcode     (r_opcode),
        .i_dec_opcode (bus.opcode_i),
        .i_mem_ready  (bus.mem_ready_i),
        .o_ctrl       (w_ctrl)
    );

    assign bus.pc_write_o   = w_ctrl.pc_write;
    assign bus.branch_eq_o  = w_ctrl.branch_eq;
    assign bus.branch_ne_o  = w_ctrl.branch_ne;
    assign bus.i_or_d_o     = w_ctrl.i_or_d;
    assign bus.mem_read_o   = w_ctrl.mem_read;
    assign bus.mem_write_o  = w_ctrl.mem_write;
    assign bus.ir_write_o   = w_ctrl.ir_write;
    assign bus.mem_to_reg_o = w_ctrl.mem_to_reg;
    assign bus.reg_dst_o    = w_ctrl.reg_dst;
    assign bus.reg_write_o  = w_ctrl.reg_write;
    assign bus.alu_src_a_o  = w_ctrl.alu_src_a;
    assign bus.alu_src_b_o  = w_ctrl.alu_src_b;
    assign bus.pc_source_o  = w_ctrl.pc_source;
    assign bus.alu_op_o     = ALU_OP_W'(w_ctrl.alu_op);
    assign bus.illegal_o    = w_ctrl.illegal;
    assign bus.state_o      = STATE_W'(r_state);

`ifdef MC_CTRL_PERF_EN
    logic             w_retire;
    logic             w_stall;
    logic [CNT_W-1:0] r_instr_cnt;
    logic [CNT_W-1:0] r_stall_cnt;

    // Retire = entering FETCH from a finishing state; illegal NOPs count too.
    always_comb begin
        w_retire = 1'b0;
        case (r_state)
            S_DECODE:  w_retire = ~is_legal(bus.opcode_i);
            S_R_WB, S_I_WB, S_MEM_WB,
            S_BRANCH, S_JUMP: w_retire = 1'b1;
            S_MEM_WR:  w_retire = bus.mem_ready_i;
            default:   w_retire = 1'b0;
        endcase
    end

    assign w_stall = ~bus.mem_ready_i &&
                     ((r_state == S_FETCH) || (r_state == S_MEM_RD) || (r_state == S_MEM_WR));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_instr_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_retire) r_instr_cnt <= r_instr_cnt + 1'b1;
            if (w_stall)  r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign bus.instr_cnt_o = r_instr_cnt;
    assign bus.stall_cnt_o = r_stall_cnt;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed vector table, reset/wait-state
// sequences, and a randomized run against a step-list reference model.
module tb_multicycle_control;
    import mips_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    multicycle_control_if bus ();
    multicycle_control dut (.clk(clk), .reset(reset), .bus(bus));

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic bit legal_op(input logic [5:0] op);
        return (op == 6'h00) || (op == 6'h02) || (op == 6'h03) || (op == 6'h04) ||
               (op == 6'h05) || (op == 6'h08) || (op == 6'h0D) || (op == 6'h0F) ||
               (op == 6'h23) || (op == 6'h2B);
    endfunction

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [5:0] op;
        int dstalls;   // wait cycles injected on the data-memory access
        int cyc;       // cycles until back in FETCH
        int rw_cyc;    // cycle holding reg_write (0 = none)
        int rdst;
        int mw_n;      // cycles with mem_write high
        int ill_n;
        int beq_n;
        int bne_n;
        int pcw_n;
        int alu3;      // alu_op in cycle 3 (-1 = not checked)
    } vec_t;

    vec_t vecs[12];

    task automatic run_vec(input vec_t v, input int idx);
        int c = 0, used = 0, rw_cyc = 0, rdst = 0, mw = 0, ill = 0;
        int beq = 0, bne = 0, pcw = 0, alu3 = -1;
        bit done = 0, rdy;
`ifdef MC_CTRL_PERF_EN
        logic [31:0] ic0 = 32'(bus.instr_cnt_o);
        logic [31:0] sc0 = 32'(bus.stall_cnt_o);
`endif
        bus.opcode_i = v.op;
        while (!done && c < 40) begin
            c++;
            rdy = !((bus.mem_write_o || (bus.mem_read_o && bus.i_or_d_o)) && used < v.dstalls);
            if (!rdy) used++;
            bus.mem_ready_i = rdy;
            #1;
            if (bus.reg_write_o) begin rw_cyc = c; rdst = bus.reg_dst_o; end
            mw  += bus.mem_write_o;
            ill += bus.illegal_o;
            beq += bus.branch_eq_o;
            bne += bus.branch_ne_o;
            pcw += bus.pc_write_o;
            if (c == 3) alu3 = bus.alu_op_o;
            @(posedge clk); #1;
            if (bus.state_o == 4'(S_FETCH)) done = 1;
            @(negedge clk);
        end
        chk($sformatf("vec%0d.done", idx), done, 1);
        chk($sformatf("vec%0d.cycles", idx), c, v.cyc);
        chk($sformatf("vec%0d.rw_cycle", idx), rw_cyc, v.rw_cyc);
        if (v.rw_cyc != 0) chk($sformatf("vec%0d.reg_dst", idx), rdst, v.rdst);
        chk($sformatf("vec%0d.mem_write_n", idx), mw, v.mw_n);
        chk($sformatf("vec%0d.illegal_n", idx), ill, v.ill_n);
        chk($sformatf("vec%0d.beq_n", idx), beq, v.beq_n);
        chk($sformatf("vec%0d.bne_n", idx), bne, v.bne_n);
        chk($sformatf("vec%0d.pc_write_n", idx), pcw, v.pcw_n);
        if (v.alu3 >= 0) chk($sformatf("vec%0d.alu_c3", idx), alu3, v.alu3);
`ifdef MC_CTRL_PERF_EN
        chk($sformatf("vec%0d.instr_cnt", idx), 32'(bus.instr_cnt_o) - ic0, 1);
        chk($sformatf("vec%0d.stall_cnt", idx), 32'(bus.stall_cnt_o) - sc0, v.dstalls);
`endif
    endtask

    // ---------------- reference model: per-instruction step list ----------------
    typedef struct {
        bit wait_mem;   // repeats until mem_ready
        bit is_dec;     // opcode must be presented this step
        int mr, mw, rw, pcw, irw, ill, beq, bne;  // 2 = follows mem_ready
        int iod, srca, srcb, alu, psrc, rdst, m2r; // -1 = don't care
    } step_t;

    step_t q[$];

    function automatic step_t mk();
        step_t s;
        s.wait_mem = 0; s.is_dec = 0;
        s.mr = 0; s.mw = 0; s.rw = 0; s.pcw = 0; s.irw = 0; s.ill = 0; s.beq = 0; s.bne = 0;
        s.iod = -1; s.srca = -1; s.srcb = -1; s.alu = -1; s.psrc = -1; s.rdst = -1; s.m2r = -1;
        return s;
    endfunction

    function automatic step_t wb(input int rdst, input int m2r);
        step_t s = mk();
        s.rw = 1; s.rdst = rdst; s.m2r = m2r;
        return s;
    endfunction

    function automatic step_t ex(input int srca, input int srcb, input int alu);
        step_t s = mk();
        s.srca = srca; s.srcb = srcb; s.alu = alu;
        return s;
    endfunction

    function automatic void push_instr(input logic [5:0] op);
        step_t s;
        s = mk(); s.wait_mem = 1; s.mr = 1; s.iod = 0; s.srca = 0; s.srcb = 1;
        s.alu = 4; s.psrc = 0; s.pcw = 2; s.irw = 2;
        q.push_back(s);
        s = ex(0, 3, 4); s.is_dec = 1; s.ill = legal_op(op) ? 0 : 1;
        q.push_back(s);
        case (op)
            6'h00: begin q.push_back(ex(1, 0, 7)); q.push_back(wb(1, 0)); end
            6'h08: begin q.push_back(ex(1, 2, 4)); q.push_back(wb(0, 0)); end
            6'h0D: begin q.push_back(ex(1, 2, 6)); q.push_back(wb(0, 0)); end
            6'h0F: begin q.push_back(ex(1, 2, 3)); q.push_back(wb(0, 0)); end
            6'h23: begin
                q.push_back(ex(1, 2, 4));
                s = mk(); s.wait_mem = 1; s.mr = 1; s.iod = 1; q.push_back(s);
                q.push_back(wb(0, 1));
            end
            6'h2B: begin
                q.push_back(ex(1, 2, 4));
                s = mk(); s.wait_mem = 1; s.mw = 1; s.iod = 1; q.push_back(s);
            end
            6'h04, 6'h05: begin
                s = ex(1, 0, 5); s.psrc = 1;
                s.beq = (op == 6'h04); s.bne = (op == 6'h05);
                q.push_back(s);
            end
            6'h02, 6'h03: begin
                s = mk(); s.psrc = 2; s.pcw = 1;
                if (op == 6'h03) begin s.rw = 1; s.rdst = 2; s.m2r = 0; end
                q.push_back(s);
            end
            default: ;
        endcase
    endfunction

    task automatic cmp_step(input step_t s, input bit rdy);
        chk("rnd.mem_read",  bus.mem_read_o,  s.mr);
        chk("rnd.mem_write", bus.mem_write_o, s.mw);
        chk("rnd.reg_write", bus.reg_write_o, s.rw);
        chk("rnd.pc_write",  bus.pc_write_o,  (s.pcw == 2) ? int'(rdy) : s.pcw);
        chk("rnd.ir_write",  bus.ir_write_o,  (s.irw == 2) ? int'(rdy) : s.irw);
        chk("rnd.illegal",   bus.illegal_o,   s.ill);
        chk("rnd.branch_eq", bus.branch_eq_o, s.beq);
        chk("rnd.branch_ne", bus.branch_ne_o, s.bne);
        if (s.iod  >= 0) chk("rnd.i_or_d",     bus.i_or_d_o,     s.iod);
        if (s.srca >= 0) chk("rnd.alu_src_a",  bus.alu_src_a_o,  s.srca);
        if (s.srcb >= 0) chk("rnd.alu_src_b",  bus.alu_src_b_o,  s.srcb);
        if (s.alu  >= 0) chk("rnd.alu_op",     bus.alu_op_o,     s.alu);
        if (s.psrc >= 0) chk("rnd.pc_source",  bus.pc_source_o,  s.psrc);
        if (s.rdst >= 0) chk("rnd.reg_dst",    bus.reg_dst_o,    s.rdst);
        if (s.m2r  >= 0) chk("rnd.mem_to_reg", bus.mem_to_reg_o, s.m2r);
    endtask

    logic [5:0] legal_list[10] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05,
                                   6'h08, 6'h0D, 6'h0F, 6'h23, 6'h2B};

    initial begin
        int retired = 0, stalls = 0;
        logic [5:0] cur = '0;
        step_t s;
        bit rdy;
        bit seen;

        vecs[0]  = '{6'h00, 0, 4, 4,  1, 0, 0, 0, 0, 1,  7};
        vecs[1]  = '{6'h23, 3, 8, 8,  0, 0, 0, 0, 0, 1,  4};
        vecs[2]  = '{6'h2B, 2, 6, 0, -1, 3, 0, 0, 0, 1,  4};
        vecs[3]  = '{6'h08, 0, 4, 4,  0, 0, 0, 0, 0, 1,  4};
        vecs[4]  = '{6'h0D, 0, 4, 4,  0, 0, 0, 0, 0, 1,  6};
        vecs[5]  = '{6'h0F, 0, 4, 4,  0, 0, 0, 0, 0, 1,  3};
        vecs[6]  = '{6'h04, 0, 3, 0, -1, 0, 0, 1, 0, 1,  5};
        vecs[7]  = '{6'h05, 0, 3, 0, -1, 0, 0, 0, 1, 1,  5};
        vecs[8]  = '{6'h02, 0, 3, 0, -1, 0, 0, 0, 0, 2, -1};
        vecs[9]  = '{6'h03, 0, 3, 3,  2, 0, 0, 0, 0, 2, -1};
        vecs[10] = '{6'h3F, 0, 2, 0, -1, 0, 1, 0, 0, 1, -1};
        vecs[11] = '{6'h23, 0, 5, 5,  0, 0, 0, 0, 0, 1,  4};

        // Reset state
        reset = 1'b0;
        bus.opcode_i = '0;
        bus.mem_ready_i = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("rst.state",     bus.state_o, 32'(S_FETCH));
        chk("rst.mem_read",  bus.mem_read_o, 1);
        chk("rst.mem_write", bus.mem_write_o, 0);
        chk("rst.reg_write", bus.reg_write_o, 0);
        chk("rst.pc_write",  bus.pc_write_o, 0);
        chk("rst.ir_write",  bus.ir_write_o, 0);
`ifdef MC_CTRL_PERF_EN
        chk("rst.instr_cnt", 32'(bus.instr_cnt_o), 0);
        chk("rst.stall_cnt", 32'(bus.stall_cnt_o), 0);
`endif
        reset = 1'b1;

        for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

        // Reset in the middle of a store wait
        bus.opcode_i = 6'h2B;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (bus.mem_write_o) seen = 1;
            else begin
                bus.mem_ready_i = 1'b1;
                @(posedge clk); @(negedge clk);
            end
        end
        chk("memwr.reached", seen, 1);
        bus.mem_ready_i = 1'b0;
        @(posedge clk); #2;
        chk("memwr.hold", bus.mem_write_o, 1);
        chk("memwr.iord", bus.i_or_d_o, 1);
        reset = 1'b0;
        #1;
        chk("memwr.rst_write", bus.mem_write_o, 0);
        chk("memwr.rst_state", bus.state_o, 32'(S_FETCH));
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("memwr.rel_read",  bus.mem_read_o, 1);
        chk("memwr.rel_state", bus.state_o, 32'(S_FETCH));

        // Randomized run from a fresh reset
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            if (q.size() == 0) begin
                cur = ($urandom_range(0, 3) != 0) ? legal_list[$urandom_range(0, 9)]
                                                 : 6'($urandom);
                push_instr(cur);
            end
            s = q[0];
            rdy = ($urandom_range(0, 2) != 0);
            bus.mem_ready_i = rdy;
            bus.opcode_i = s.is_dec ? cur : 6'($urandom);
            #1;
            cmp_step(s, rdy);
            if (s.wait_mem && !rdy) stalls++;
            else begin
                void'(q.pop_front());
                if (q.size() == 0) retired++;
            end
            @(negedge clk);
        end
`ifdef MC_CTRL_PERF_EN
        chk("rnd.instr_cnt", 32'(bus.instr_cnt_o), retired);
        chk("rnd.stall_cnt", 32'(bus.stall_cnt_o), stalls);
`endif
        chk("rnd.progress", (retired > 100) ? 1 : 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
